itrace_ringbuf: RTL and testbench
=================================

# itrace_ringbuf

Instruction-trace capture buffer for the NPC core. It records every retired instruction (pc, inst, op_type, retire sequence number) into a DEPTH-entry ring. On a halt trigger (ebreak, ecall, or external request) it freezes and drains the last ≤DEPTH records, oldest first, over a valid/ready port. A DPI-side host reader consumes that port to print the crash/exit history. It sits beside the per-cycle trace monitor and is fed by the same commit-stage signals.

## Interface
- DEPTH, 16, ring entries; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width (derived, do not override)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  an instruction retires this cycle
- in_pc  in  32  retiring instruction address
- in_inst  in  32  retiring instruction word
- in_op_type  in  6  decoded op_type code
- ext_trig  in  1  external halt request, level-sampled
- rearm  in  1  in DONE: clear buffer and return to CAPTURE
- out_valid  out  1  drain record available
- out_ready  in  1  host reader accepts record
- out_pc  out  32  record pc
- out_inst  out  32  record instruction word
- out_op_type  out  6  record op_type
- out_seq  out  32  record retire sequence number
- out_last  out  1  record is the final one of the drain
- done  out  1  drain complete, buffer frozen

## Operation
- States: CAPTURE (reset state), DRAIN, DONE.
- CAPTURE:
  - While in_valid=1, write {in_pc, in_inst, in_op_type, seq} at wr_ptr.
  - Then wr_ptr += 1 (wraps mod DEPTH), seq += 1 (32-bit, wraps), and cnt saturates at DEPTH.
- Trigger, evaluated in CAPTURE only, is any of:
  - in_valid=1 with in_inst==INST_EBREAK (0x00100073);
  - in_valid=1 with in_inst==INST_ECALL (0x00000073);
  - ext_trig=1.
- The triggering instruction is itself captured as the newest record.
- On trigger, compute post-write values cnt' and wr_ptr' (including any same-cycle write). Then:
  - rd_ptr ← wr_ptr' − cnt' (mod DEPTH);
  - rem ← cnt';
  - next state is DRAIN if cnt'>0, else DONE.
- DRAIN:
  - out_valid=1.
  - out_* equals the entry at rd_ptr; out_last=(rem==1).
  - On out_valid&&out_ready: rd_ptr += 1 (wraps), rem −= 1. If rem was 1, go to DONE.
- DONE: done=1 and out_valid=0. rearm=1 clears wr_ptr, cnt and seq to 0 and returns to CAPTURE.
- in_valid, ext_trig and triggers are ignored in DRAIN and DONE; nothing is written. rearm is ignored outside DONE.
- Arithmetic: pointers are PTR_W-bit modular; cnt and rem are PTR_W+1 bits; seq is a 32-bit unsigned wrap.

## Timing
- Reset values:
  - state=CAPTURE; wr_ptr, rd_ptr, cnt, rem, seq = 0.
  - out_valid=0, out_last=0, done=0.
  - out_pc, out_inst, out_op_type, out_seq = 0.
- out_* are forced to 0 whenever out_valid=0.
- Capture: an entry is written at the rising edge where in_valid=1 in CAPTURE. No latency beyond that edge.
- Trigger at edge N puts out_valid=1 from cycle N+1. The first record is presented in that cycle.
- Throughput: one record per cycle while out_ready stays high.
- out_* and out_last must hold stable while out_valid=1 and out_ready=0.
- The last handshake at edge M gives done=1 and out_valid=0 from cycle M+1.
- rearm at edge K gives done=0 and capture enabled from cycle K+1. An in_valid in cycle K is not captured.
- Simultaneous ext_trig and a non-trigger retire: the retire is captured, then the drain starts.
- Wrap: after >DEPTH retires, the drain starts at the oldest surviving entry (wr_ptr') and delivers exactly DEPTH records.
- Reset asserted mid-DRAIN: out_valid drops asynchronously and all state clears. The drain is not resumed.

## Structure
- Package npc_trace_pkg holds:
  - INST_EBREAK and INST_ECALL;
  - the trace_state_t enum {CAPTURE, DRAIN, DONE};
  - the trace_rec_t struct {pc[31:0], inst[31:0], op_type[5:0], seq[31:0]} (102 bits).
- Sub-module trace_ram:
  - DEPTH×trace_rec_t storage;
  - synchronous write port, asynchronous read port;
  - no reset on the storage array.
- The top level holds the FSM, pointers, counters and output gating.

## Test plan
All scenarios use DEPTH=4.
- 3 retires with pc 0x80000000/04/08, the third inst=0x00100073 → 3 records pc 00,04,08; seq 0,1,2; out_last on the third; done one cycle after the last handshake.
- 6 retires pc 0x100..0x114, then ext_trig → 4 records pc 0x108,0x10C,0x110,0x114; seq 2..5; out_last on 0x114.
- Drain with out_ready toggling 1,0,0,1,… → no record lost or duplicated; out_* stable across stalled cycles.
- ext_trig immediately after reset with no retires → out_valid never rises; done=1 the next cycle.
- rst pulse mid-DRAIN after 1 handshake → out_valid=0 immediately. A subsequent ecall (0x00000073) as the first retire drains 1 record with seq=0 and out_last=1.
- In DONE: rearm, then 2 retires and ext_trig → 2 records with seq 0,1. Retires applied during DONE are never output.

Source files
------------

// File: rtl/itrace_ringbuf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : npc_trace_pkg
// Description : Shared types and constants for the instruction-trace ring
//               buffer. Provides the halt-instruction encodings, the capture
//               FSM state type and the packed trace record layout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package npc_trace_pkg;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } trace_state_t;

  // 102-bit record: pc, instruction word, op_type, retire sequence number
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  op_type;
    logic [31:0] seq;
  } trace_rec_t;

  // True for the two instructions that end a run and freeze the buffer
  function automatic logic is_halt_inst(input logic [31:0] inst);
    return (inst == INST_EBREAK) || (inst == INST_ECALL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/itrace_ringbuf_if.sv
`default_nettype none
// ============================================================================
// Interface   : itrace_ringbuf_if
// Description : Retire-side input bundle and valid/ready drain port of the
//               instruction-trace ring buffer.
// Signals     : in_valid/in_pc/in_inst/in_op_type - commit-stage retire info
//               out_valid/out_ready                - drain handshake
//               out_pc/out_inst/out_op_type/out_seq/out_last - drained record
// Modports    : slave  - the ring buffer (consumes retires, drives drain)
//               master - the core/host side
// Revision    : 1.0 - initial release
// ============================================================================
interface itrace_ringbuf_if;

  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [5:0]  in_op_type;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [5:0]  out_op_type;
  logic [31:0] out_seq;
  logic        out_last;

  modport slave (
    input  in_valid, in_pc, in_inst, in_op_type, out_ready,
    output out_valid, out_pc, out_inst, out_op_type, out_seq, out_last
  );

  modport master (
    output in_valid, in_pc, in_inst, in_op_type, out_ready,
    input  out_valid, out_pc, out_inst, out_op_type, out_seq, out_last
  );

endinterface
`default_nettype wire

// File: rtl/itrace_ringbuf_ram.sv
`default_nettype none
// ============================================================================
// Module      : trace_ram
// Description : DEPTH x trace_rec_t storage with one synchronous write port
//               and one asynchronous (combinational) read port. The array is
//               deliberately not reset; validity is tracked by the caller.
// Ports       : clk    - core clock
//               we     - write enable
//               waddr  - write address
//               wdata  - record to store
//               raddr  - read address
//               rdata  - record at raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ram
  import npc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [PTR_W-1:0] waddr,
  input  wire trace_rec_t       wdata,
  input  wire logic [PTR_W-1:0] raddr,
  output      trace_rec_t       rdata
);

  trace_rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/itrace_ringbuf.sv
`default_nettype none
// ============================================================================
// Module      : itrace_ringbuf
// Description : Instruction-trace capture buffer. Records every retired
//               instruction into a DEPTH-entry ring; on ebreak, ecall or an
//               external request it freezes and drains the last <=DEPTH
//               records oldest first over a valid/ready port, then waits in
//               DONE until rearmed.
// Ports       : clk      - core clock
//               rst      - asynchronous active-high reset
//               bus      - itrace_ringbuf_if.slave (retire in, drain out)
//               ext_trig - external halt request (level sampled in CAPTURE)
//               rearm    - in DONE, clear the buffer and resume capture
//               done     - drain complete, buffer frozen
// Revision    : 1.0 - initial release
// ============================================================================
module itrace_ringbuf
  import npc_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  itrace_ringbuf_if.slave    bus,
  input  wire logic          ext_trig,
  input  wire logic          rearm,
  output      logic          done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  trace_state_t     state_q,  state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] rem_q,    rem_d;
  logic [31:0]      seq_q,    seq_d;

  logic             wr_en;
  logic             trig;
  trace_rec_t       wr_rec;
  trace_rec_t       rd_rec;

  // Record being written this cycle carries the current sequence number
  always_comb begin
    wr_rec         = '0;
    wr_rec.pc      = bus.in_pc;
    wr_rec.inst    = bus.in_inst;
    wr_rec.op_type = bus.in_op_type;
    wr_rec.seq     = seq_q;
  end

  assign wr_en = (state_q == CAPTURE) && bus.in_valid;
  assign trig  = (state_q == CAPTURE) &&
                 (ext_trig || (bus.in_valid && is_halt_inst(bus.in_inst)));

  trace_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_rec),
    .raddr (rd_ptr_q),
    .rdata (rd_rec)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    seq_d    = seq_q;

    unique case (state_q)
      CAPTURE: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          seq_d    = seq_q + 32'd1;
          cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
        // The oldest surviving record sits cnt' slots behind the post-write
        // pointer; with a full ring this lands exactly on wr_ptr'.
        if (trig) begin
          rd_ptr_d = wr_ptr_d - cnt_d[PTR_W-1:0];
          rem_d    = cnt_d;
          state_d  = (cnt_d != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          rem_d    = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (rearm) begin
          wr_ptr_d = '0;
          cnt_d    = '0;
          seq_d    = '0;
          state_d  = CAPTURE;
        end
      end
      default: begin
        state_d = CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CAPTURE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      seq_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      seq_q    <= seq_d;
    end
  end

  // Outputs decode directly from registered state, so a reset drops
  // out_valid immediately; record fields are zeroed whenever not valid.
  assign bus.out_valid   = (state_q == DRAIN);
  assign bus.out_pc      = bus.out_valid ? rd_rec.pc      : 32'd0;
  assign bus.out_inst    = bus.out_valid ? rd_rec.inst    : 32'd0;
  assign bus.out_op_type = bus.out_valid ? rd_rec.op_type : 6'd0;
  assign bus.out_seq     = bus.out_valid ? rd_rec.seq     : 32'd0;
  assign bus.out_last    = bus.out_valid && (rem_q == CNT_ONE);
  assign done            = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_itrace_ringbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_itrace_ringbuf
// Description : Self-checking bench for itrace_ringbuf (DEPTH=4). A history
//               queue model keeps the last DEPTH retires; a trigger snapshots
//               it as the expected drain sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itrace_ringbuf;
  import npc_trace_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic ext_trig;
  logic rearm;
  logic done;

  itrace_ringbuf_if bus();

  itrace_ringbuf #(.DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ext_trig (ext_trig),
    .rearm    (rearm),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = capturing, 1 = draining, 2 = frozen
  trace_rec_t  hist[$];
  trace_rec_t  exp_q[$];
  int          mode;
  logic [31:0] seq_m;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus; the model is updated using the pre-edge mode.
  task automatic apply(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [5:0] op, input bit ext, input bit rm);
    trace_rec_t r;
    bus.in_valid   = v;
    bus.in_pc      = pc;
    bus.in_inst    = inst;
    bus.in_op_type = op;
    bus.out_ready  = 1'b0;
    ext_trig       = ext;
    rearm          = rm;
    @(posedge clk);
    if (mode == 0) begin
      if (v) begin
        r.pc = pc; r.inst = inst; r.op_type = op; r.seq = seq_m;
        hist.push_back(r);
        seq_m = seq_m + 32'd1;
        if (hist.size() > D) void'(hist.pop_front());
      end
      if (ext || (v && (inst == INST_EBREAK || inst == INST_ECALL))) begin
        exp_q = hist;
        mode  = (exp_q.size() > 0) ? 1 : 2;
      end
    end else if (mode == 2 && rm) begin
      hist.delete();
      seq_m = 32'd0;
      mode  = 0;
    end
    #1;
    bus.in_valid = 1'b0;
    ext_trig     = 1'b0;
    rearm        = 1'b0;
  endtask

  function automatic logic [31:0] plain_inst();
    return {$urandom()} & 32'hFFFF_FF80 | 32'h0000_0033;
  endfunction

  task automatic check_record();
    chk("out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("out_pc",    {32'd0, bus.out_pc},      {32'd0, exp_q[0].pc});
    chk("out_inst",  {32'd0, bus.out_inst},    {32'd0, exp_q[0].inst});
    chk("out_op",    {58'd0, bus.out_op_type}, {58'd0, exp_q[0].op_type});
    chk("out_seq",   {32'd0, bus.out_seq},     {32'd0, exp_q[0].seq});
    chk("out_last",  {63'd0, bus.out_last},    {63'd0, exp_q.size() == 1});
  endtask

  task automatic check_idle_done();
    chk("done",          {63'd0, done},          64'd1);
    chk("idle_valid",    {63'd0, bus.out_valid}, 64'd0);
    chk("idle_last",     {63'd0, bus.out_last},  64'd0);
    chk("idle_pc_zero",  {32'd0, bus.out_pc},    64'd0);
    chk("idle_seq_zero", {32'd0, bus.out_seq},   64'd0);
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1,..., 2 = random.
  // Retire/trigger noise is driven throughout; the DUT must ignore it.
  task automatic drain(input int rmode);
    int budget = 0;
    bit rdy;
    while (exp_q.size() > 0 && budget < 200) begin
      check_record();
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (budget % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready  = rdy;
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_pc      = $urandom();
      bus.in_inst    = INST_EBREAK;
      ext_trig       = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (rdy) void'(exp_q.pop_front());
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      ext_trig      = 1'b0;
      budget++;
    end
    chk("drain_budget", 64'(exp_q.size()), 64'd0);
    mode = 2;
    check_idle_done();
  endtask

  initial begin
    rst = 1'b1; ext_trig = 1'b0; rearm = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.in_op_type = '0;
    bus.out_ready = 1'b0;
    mode = 0; seq_m = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_done",  {63'd0, done},          64'd0);
    chk("rst_last",  {63'd0, bus.out_last},  64'd0);
    chk("rst_pc",    {32'd0, bus.out_pc},    64'd0);
    chk("rst_seq",   {32'd0, bus.out_seq},   64'd0);

    // Three retires ending in ebreak
    apply(1, 32'h8000_0000, 32'h0000_0013, 6'd1, 0, 0);
    apply(1, 32'h8000_0004, 32'h0010_0093, 6'd2, 0, 0);
    apply(1, 32'h8000_0008, INST_EBREAK,   6'd3, 0, 0);
    chk("s1_first_pc", {32'd0, bus.out_pc}, 64'h8000_0000);
    drain(0);

    // Rearm, six retires wrapping a 4-deep ring, external trigger, stalled drain
    apply(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      apply(1, 32'h100 + 32'(4 * i), plain_inst(), 6'($urandom()), 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    chk("s2_first_pc",  {32'd0, bus.out_pc},  64'h108);
    chk("s2_first_seq", {32'd0, bus.out_seq}, 64'd2);
    drain(1);

    // Retires while frozen are ignored; in_valid in the rearm cycle too
    apply(1, 32'hDEAD_0000, plain_inst(), 6'd5, 0, 0);
    apply(1, 32'hDEAD_0004, plain_inst(), 6'd5, 1, 0);
    apply(1, 32'hDEAD_0008, plain_inst(), 6'd5, 0, 1);
    apply(1, 32'h200, plain_inst(), 6'd7, 0, 0);
    apply(1, 32'h204, plain_inst(), 6'd8, 1, 0);
    chk("s3_first_seq", {32'd0, bus.out_seq}, 64'd0);
    drain(0);

    // External trigger right after reset with nothing captured
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    hist.delete(); exp_q.delete(); seq_m = 32'd0; mode = 0;
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 1, 0);
    drain(0);

    // Reset in the middle of a drain, then an ecall as first retire
    apply(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      apply(1, 32'h300 + 32'(4 * i), plain_inst(), 6'd9, 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    check_record();
    bus.out_ready = 1'b1;
    @(posedge clk);
    void'(exp_q.pop_front());
    #1 bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_done",  {63'd0, done},          64'd0);
    chk("midrst_pc",    {32'd0, bus.out_pc},    64'd0);
    hist.delete(); exp_q.delete(); seq_m = 32'd0; mode = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    apply(1, 32'h400, INST_ECALL, 6'd4, 0, 0);
    chk("ecall_seq",  {32'd0, bus.out_seq},  64'd0);
    chk("ecall_last", {63'd0, bus.out_last}, 64'd1);
    drain(0);

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      int n;
      apply(0, 0, 0, 0, 0, 1);
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        logic [31:0] inst;
        int sel;
        sel  = $urandom_range(0, 15);
        inst = (sel == 0) ? INST_EBREAK : (sel == 1) ? INST_ECALL : plain_inst();
        apply(1'($urandom_range(0, 1)), $urandom(), inst, 6'($urandom()),
              $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
      end
      apply(0, 0, 0, 0, 1, 0);
      drain(2);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
